reg_file_idu: RTL and testbench
===============================

// Module: reg_file_idu
// PURPOSE
//   Parametrised CPU register file: NUM_PAIRS split byte-pair registers (WZ,BC,DE,HL)
//   plus NUM_WIDE full-width registers (SP,PC). Adds two byte read ports and an
//   integrated increment/decrement unit (IDU) for HL+/HL-, PUSH/POP and PC fetch.
//   Adds a write-collision monitor. Sits between the decoder/sequencer, the ALU, and the address bus.
// PARAMETERS
//   W          8   byte width; wide registers and pairs are 2*W
//   NUM_PAIRS  4   split pairs; byte index b = 2*pair+{0:hi,1:lo}
//   NUM_WIDE   2   full-width regs; wide index = NUM_PAIRS+k (SP=4, PC=5)
//   TAP_SEL    3   wide index driven continuously on o_Tap (HL)
//   B8/B16     clog2(2*NUM_PAIRS) / clog2(NUM_PAIRS+NUM_WIDE); derived, not overridable
// PORTS
//   i_Clk        in   1      system clock, rising edge
//   i_nRst       in   1      asynchronous active-low reset
//   i_Enable     in   1      tick enable; low = no state change
//   i_Rd8A_Sel   in   B8     byte read index, port A
//   o_Rd8A       out  W      byte read data, port A
//   i_Rd8B_Sel   in   B8     byte read index, port B
//   o_Rd8B       out  W      byte read data, port B
//   i_Rd16_Sel   in   B16    wide read index
//   o_Rd16       out  2W     wide read data
//   i_Wr8_En     in   1      byte write strobe
//   i_Wr8_Sel    in   B8     byte write index
//   i_Wr8_Data   in   W      byte write data
//   i_Wr16_En    in   1      wide write strobe
//   i_Wr16_Sel   in   B16    wide write index
//   i_Wr16_Data  in   2W     wide write data
//   i_Idu_En     in   1      IDU request
//   i_Idu_Sel    in   B16    IDU target wide index
//   i_Idu_Op     in   2      00 inc, 01 dec, 10/11 hold (no writeback)
//   o_Idu_Addr   out  2W     pre-modify value of IDU target (address bus)
//   o_Tap        out  2W     stored (unbypassed) value of TAP_SEL
//   o_Collision  out  1      registered: >1 write source hit the same byte last enabled cycle
// BEHAVIOUR
//   - Reset (async, i_nRst=0): all registers 0, o_Collision 0. Reads then return 0.
//   - State updates only on rising i_Clk with i_Enable=1; i_Enable=0 holds all state
//     (o_Collision included), and read ports show stored values (no bypass).
//   - Next value per byte is resolved with priority Wr16 > IDU writeback > Wr8.
//     Wr8 to a pair byte changes only that byte; Wr16/IDU to a pair writes both bytes.
//     Wr8 never targets a wide register.
//   - Read ports are write-through when i_Enable=1: o_Rd8A/B and o_Rd16 show the resolved
//     next value of the selected register in the same cycle (0 cycles latency). o_Tap and
//     o_Idu_Addr never bypass.
//   - IDU: o_Idu_Addr = stored value of i_Idu_Sel (combinational). If i_Idu_Op is inc/dec,
//     writeback = value +/-1 mod 2^(2W). FFFF+1=0000 and 0000-1=FFFF with no flag. Hold ops
//     drive the address only.
//   - Collision: o_Collision <= 1 on the enabled edge if two or more of {Wr8, Wr16,
//     IDU inc/dec} target a common byte; else 0. The lower-priority write is dropped.
//   - Out-of-range indices: reads return 0, writes and IDU writeback are ignored,
//     and o_Idu_Addr = 0. No collision is counted for them.
//   - Reset asserted mid-cycle overrides any pending write; the first enabled edge after
//     release behaves normally.
// TESTING
//   1 reset, then Rd16 all indices -> 0000; o_Collision=0; o_Tap=0000.
//   2 Wr8 b=2 (B) 0x12, next cycle Wr8 b=3 (C) 0x34 -> Rd16 idx1=1234.
//     Same-cycle Rd8A b=3 bypass shows 0x34 before the edge.
//   3 Wr16 idx3=FFFF; IDU idx3 inc -> o_Idu_Addr=FFFF, then HL=0000 and o_Tap=0000.
//     Dec from 0000 -> FFFF.
//   4 same cycle: Wr16 idx1=AAAA, Wr8 b=3=0x55, IDU idx1 dec -> BC=AAAA; next cycle
//     o_Collision=1, and the following clean cycle clears it to 0.
//   5 i_Enable=0 with Wr16 idx5=0100 and IDU idx4 inc -> no change; Rd16 shows old values.
//     o_Collision is held.
//   6 Wr16 idx5=0150 with i_nRst pulsed low before the edge -> PC=0000; Rd8 idx 7
//     (out of range at NUM_PAIRS=3 build) -> 0.

Source files
------------

// File: rtl/reg_file_idu.sv
// CPU register file: split byte pairs plus full-width registers, two byte read ports,
// one wide read port, an inc/dec unit on the address path and a write-collision flag.
module reg_file_idu #(
  parameter int W         = 8,
  parameter int NUM_PAIRS = 4,
  parameter int NUM_WIDE  = 2,
  parameter int TAP_SEL   = 3,
  localparam int B8       = $clog2(2 * NUM_PAIRS),
  localparam int B16      = $clog2(NUM_PAIRS + NUM_WIDE)
) (
  input  logic           i_Clk,
  input  logic           i_nRst,
  input  logic           i_Enable,
  input  logic [B8-1:0]  i_Rd8A_Sel,
  output logic [W-1:0]   o_Rd8A,
  input  logic [B8-1:0]  i_Rd8B_Sel,
  output logic [W-1:0]   o_Rd8B,
  input  logic [B16-1:0] i_Rd16_Sel,
  output logic [2*W-1:0] o_Rd16,
  input  logic           i_Wr8_En,
  input  logic [B8-1:0]  i_Wr8_Sel,
  input  logic [W-1:0]   i_Wr8_Data,
  input  logic           i_Wr16_En,
  input  logic [B16-1:0] i_Wr16_Sel,
  input  logic [2*W-1:0] i_Wr16_Data,
  input  logic           i_Idu_En,
  input  logic [B16-1:0] i_Idu_Sel,
  input  logic [1:0]     i_Idu_Op,
  output logic [2*W-1:0] o_Idu_Addr,
  output logic [2*W-1:0] o_Tap,
  output logic           o_Collision
);

  localparam int NUM_REGS  = NUM_PAIRS + NUM_WIDE;
  localparam int NUM_BYTES = 2 * NUM_PAIRS;
  localparam logic [2*W-1:0] ONE = 1;

  // Pair registers hold the hi byte (even byte index) in the upper half.
  logic [2*W-1:0] regs      [NUM_REGS];
  logic [2*W-1:0] next_regs [NUM_REGS];
  logic [2*W-1:0] view      [NUM_REGS];

  logic           wr8_ok;
  logic           wr16_ok;
  logic           idu_ok;
  logic           idu_wb;
  logic [2*W-1:0] idu_addr;
  logic [2*W-1:0] idu_val;
  logic           coll_p0;
  logic           coll_p1;

  function automatic logic [2*W-1:0] idu_step(input logic [2*W-1:0] v, input logic dec);
    return dec ? (v - ONE) : (v + ONE);
  endfunction

  always_comb begin
    wr8_ok  = i_Wr8_En  && (int'(i_Wr8_Sel)  < NUM_BYTES);
    wr16_ok = i_Wr16_En && (int'(i_Wr16_Sel) < NUM_REGS);
    idu_ok  = i_Idu_En  && (int'(i_Idu_Sel)  < NUM_REGS);
    idu_wb  = idu_ok && !i_Idu_Op[1];
    idu_addr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_Idu_Sel == B16'(i)) idu_addr = regs[i];
    end
    idu_val = idu_step(idu_addr, i_Idu_Op[0]);
  end

  // Per-register next-value resolution: Wr16 > IDU writeback > Wr8.
  always_comb begin
    logic w16, wi, w8_hi, w8_lo;
    coll_p0 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w16   = wr16_ok && (i_Wr16_Sel == B16'(i));
      wi    = idu_wb  && (i_Idu_Sel  == B16'(i));
      w8_hi = wr8_ok && (i < NUM_PAIRS) && (i_Wr8_Sel == B8'(2 * i));
      w8_lo = wr8_ok && (i < NUM_PAIRS) && (i_Wr8_Sel == B8'(2 * i + 1));
      next_regs[i] = regs[i];
      if (w8_hi) next_regs[i][2*W-1:W] = i_Wr8_Data;
      if (w8_lo) next_regs[i][W-1:0]   = i_Wr8_Data;
      if (wi)    next_regs[i]          = idu_val;
      if (w16)   next_regs[i]          = i_Wr16_Data;
      if ((w16 && wi) || (w16 && (w8_hi || w8_lo)) || (wi && (w8_hi || w8_lo)))
        coll_p0 = 1'b1;
    end
  end

  // Read ports see the resolved next value only while the tick is enabled.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = i_Enable ? next_regs[i] : regs[i];
    end
  end

  always_comb begin
    o_Rd8A = '0;
    o_Rd8B = '0;
    o_Rd16 = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      if (i_Rd8A_Sel == B8'(2 * i))     o_Rd8A = view[i][2*W-1:W];
      if (i_Rd8A_Sel == B8'(2 * i + 1)) o_Rd8A = view[i][W-1:0];
      if (i_Rd8B_Sel == B8'(2 * i))     o_Rd8B = view[i][2*W-1:W];
      if (i_Rd8B_Sel == B8'(2 * i + 1)) o_Rd8B = view[i][W-1:0];
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_Rd16_Sel == B16'(i)) o_Rd16 = view[i];
    end
  end

  assign o_Idu_Addr  = idu_addr;
  assign o_Tap       = regs[TAP_SEL];
  assign o_Collision = coll_p1;

  // State update boundary
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      coll_p1 <= 1'b0;
    end else if (i_Enable) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= next_regs[i];
      coll_p1 <= coll_p0;
    end
  end

endmodule

// File: tb/tb_reg_file_idu.sv
// Directed bench for reg_file_idu: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, enable-hold, mid-cycle reset and a 3-pair build.
module tb_reg_file_idu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  ra, rb, r16;
  logic        w8_en;
  logic [2:0]  w8_sel;
  logic [7:0]  w8_d;
  logic        w16_en;
  logic [2:0]  w16_sel;
  logic [15:0] w16_d;
  logic        idu_en;
  logic [2:0]  idu_sel;
  logic [1:0]  idu_op;
  logic [7:0]  rd8a, rd8b, rd8a_s, rd8b_s;
  logic [15:0] rd16, addr, tap, rd16_s, addr_s, tap_s;
  logic        coll, coll_s;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_idu dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_Enable(en),
    .i_Rd8A_Sel(ra), .o_Rd8A(rd8a), .i_Rd8B_Sel(rb), .o_Rd8B(rd8b),
    .i_Rd16_Sel(r16), .o_Rd16(rd16),
    .i_Wr8_En(w8_en), .i_Wr8_Sel(w8_sel), .i_Wr8_Data(w8_d),
    .i_Wr16_En(w16_en), .i_Wr16_Sel(w16_sel), .i_Wr16_Data(w16_d),
    .i_Idu_En(idu_en), .i_Idu_Sel(idu_sel), .i_Idu_Op(idu_op),
    .o_Idu_Addr(addr), .o_Tap(tap), .o_Collision(coll)
  );

  reg_file_idu #(.NUM_PAIRS(3)) dut_small (
    .i_Clk(clk), .i_nRst(rst_n), .i_Enable(en),
    .i_Rd8A_Sel(ra), .o_Rd8A(rd8a_s), .i_Rd8B_Sel(rb), .o_Rd8B(rd8b_s),
    .i_Rd16_Sel(r16), .o_Rd16(rd16_s),
    .i_Wr8_En(w8_en), .i_Wr8_Sel(w8_sel), .i_Wr8_Data(w8_d),
    .i_Wr16_En(w16_en), .i_Wr16_Sel(w16_sel), .i_Wr16_Data(w16_d),
    .i_Idu_En(idu_en), .i_Idu_Sel(idu_sel), .i_Idu_Op(idu_op),
    .o_Idu_Addr(addr_s), .o_Tap(tap_s), .o_Collision(coll_s)
  );

  typedef struct {
    logic        w8_en;
    logic [2:0]  w8_sel;
    logic [7:0]  w8_d;
    logic        w16_en;
    logic [2:0]  w16_sel;
    logic [15:0] w16_d;
    logic        idu_en;
    logic [2:0]  idu_sel;
    logic [1:0]  idu_op;
    logic [2:0]  ra, rb, r16;
    logic [7:0]  e_ra, e_rb;
    logic [15:0] e_r16, e_addr, e_tap;
    logic        e_coll;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; w8_en = 1'b0; w8_sel = '0; w8_d = '0;
    w16_en = 1'b0; w16_sel = '0; w16_d = '0;
    idu_en = 1'b0; idu_sel = 3'd6; idu_op = 2'b10;
    ra = '0; rb = '0; r16 = '0;
  endtask

  initial begin
    // {w8_en,sel,d, w16_en,sel,d, idu_en,sel,op, ra,rb,r16, e_ra,e_rb,e_r16,e_addr,e_tap,e_coll}
    vecs[0]  = '{1'b1, 3'd2, 8'h12, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 2'b00,
                 3'd2, 3'd3, 3'd1, 8'h12, 8'h00, 16'h1200, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 3'd3, 8'h34, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 2'b00,
                 3'd3, 3'd2, 3'd1, 8'h34, 8'h12, 16'h1234, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 16'hFFFF, 1'b0, 3'd6, 2'b00,
                 3'd6, 3'd7, 3'd3, 8'hFF, 8'hFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 2'b00,
                 3'd6, 3'd7, 3'd3, 8'h00, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 2'b00,
                 3'd6, 3'd7, 3'd3, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 2'b01,
                 3'd6, 3'd7, 3'd3, 8'hFF, 8'hFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 3'd3, 8'h55, 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd1, 2'b01,
                 3'd3, 3'd2, 3'd1, 8'hAA, 8'hAA, 16'hAAAA, 16'h1234, 16'hFFFF, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 2'b00,
                 3'd3, 3'd2, 3'd1, 8'hAA, 8'hAA, 16'hAAAA, 16'h0000, 16'hFFFF, 1'b0};
    vecs[8]  = '{1'b1, 3'd6, 8'h77, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 2'b00,
                 3'd6, 3'd7, 3'd4, 8'h77, 8'hFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
    vecs[9]  = '{1'b1, 3'd7, 8'h11, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 2'b00,
                 3'd7, 3'd6, 3'd3, 8'h00, 8'h78, 16'h7800, 16'h77FF, 16'h77FF, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 16'h1234, 1'b1, 3'd4, 2'b10,
                 3'd6, 3'd7, 3'd4, 8'h78, 8'h00, 16'h1234, 16'h0001, 16'h7800, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 16'h5555, 1'b1, 3'd4, 2'b00,
                 3'd6, 3'd7, 3'd4, 8'h78, 8'h00, 16'h5555, 16'h1234, 16'h7800, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 16'hBEEF, 1'b1, 3'd7, 2'b00,
                 3'd4, 3'd5, 3'd6, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h7800, 1'b0};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    for (int i = 0; i < 8; i++) begin
      r16 = 3'(i);
      #1;
      chk($sformatf("reset_rd16[%0d]", i), rd16, 16'h0000);
    end
    chk("reset_coll", 16'(coll), 16'h0000);
    chk("reset_tap", tap, 16'h0000);

    // Table-driven single-cycle vectors
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      idle();
      w8_en = vecs[v].w8_en;   w8_sel = vecs[v].w8_sel;   w8_d = vecs[v].w8_d;
      w16_en = vecs[v].w16_en; w16_sel = vecs[v].w16_sel; w16_d = vecs[v].w16_d;
      idu_en = vecs[v].idu_en; idu_sel = vecs[v].idu_sel; idu_op = vecs[v].idu_op;
      ra = vecs[v].ra; rb = vecs[v].rb; r16 = vecs[v].r16;
      #2;
      chk($sformatf("v%0d_rd8a", v), 16'(rd8a), 16'(vecs[v].e_ra));
      chk($sformatf("v%0d_rd8b", v), 16'(rd8b), 16'(vecs[v].e_rb));
      chk($sformatf("v%0d_rd16", v), rd16, vecs[v].e_r16);
      chk($sformatf("v%0d_addr", v), addr, vecs[v].e_addr);
      chk($sformatf("v%0d_tap", v), tap, vecs[v].e_tap);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_coll", v), 16'(coll), 16'(vecs[v].e_coll));
    end

    // Collision then a disabled cycle: state and flag hold
    @(negedge clk);
    idle();
    w16_en = 1'b1; w16_sel = 3'd2; w16_d = 16'h2222;
    w8_en = 1'b1; w8_sel = 3'd4; w8_d = 8'h99;
    @(posedge clk); #1;
    chk("hold_setup_coll", 16'(coll), 16'h0001);
    @(negedge clk);
    idle();
    en = 1'b0;
    w16_en = 1'b1; w16_sel = 3'd5; w16_d = 16'h0100;
    idu_en = 1'b1; idu_sel = 3'd4; idu_op = 2'b00;
    r16 = 3'd5; ra = 3'd4;
    #2;
    chk("hold_rd16_pc", rd16, 16'h0000);
    chk("hold_rd8_d", 16'(rd8a), 16'h0022);
    chk("hold_addr_sp", addr, 16'h5555);
    @(posedge clk); #1;
    chk("hold_coll", 16'(coll), 16'h0001);
    r16 = 3'd4; #1;
    chk("hold_rd16_sp", rd16, 16'h5555);
    r16 = 3'd5; #1;
    chk("hold_rd16_pc_after", rd16, 16'h0000);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("hold_clean_coll", 16'(coll), 16'h0000);

    // Reset pulse covering the edge of a pending write
    @(negedge clk);
    idle();
    w16_en = 1'b1; w16_sel = 3'd5; w16_d = 16'h0150;
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    idle();
    r16 = 3'd5; ra = 3'd7; rb = 3'd6;
    #2;
    chk("rst_pc", rd16, 16'h0000);
    chk("rst_tap", tap, 16'h0000);
    chk("rst_coll", 16'(coll), 16'h0000);
    chk("small_rd8a_oob", 16'(rd8a_s), 16'h0000);
    chk("small_rd8b_oob", 16'(rd8b_s), 16'h0000);
    r16 = 3'd7; #1;
    chk("small_rd16_oob", rd16_s, 16'h0000);
    @(negedge clk);
    idle();
    w16_en = 1'b1; w16_sel = 3'd5; w16_d = 16'h0150;
    @(posedge clk); #1;
    w16_en = 1'b0; r16 = 3'd5; #1;
    chk("post_rst_pc", rd16, 16'h0150);
    chk("small_pc_oob", rd16_s, 16'h0000);
    r16 = 3'd4; #1;
    chk("small_sp", rd16_s, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
